// File: rtl/wisc_pkg.sv
// Shared definitions for the WISC-SP20 pipeline: the bubble instruction word,
// primary opcode values, the data-memory access state encoding, and a small
// decode helper.
package wisc_pkg;

  // Instruction word used for bubbles and reset (opcode NOP).
  localparam logic [15:0] NOP_INSTR = 16'h0800;

  // Primary opcodes, instr[15:11].
  localparam logic [4:0] OP_HALT = 5'b00000;
  localparam logic [4:0] OP_NOP  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b10000;
  localparam logic [4:0] OP_LD   = 5'b10001;
  localparam logic [4:0] OP_STU  = 5'b10011;

  // Data-memory access controller states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_ERR    = 2'b10
  } mem_state_t;

  // A captured instruction needs a data-memory access only if it is real
  // and either reads or writes memory.
  function automatic logic is_mem_op(input logic valid, input logic rd, input logic wr);
    return valid & (rd | wr);
  endfunction

endpackage

// File: rtl/mem_access_fsm.sv
// Data-memory access sequencer for the EX/MEM register. Tracks whether an
// access is outstanding, drives the memory enable, raises back-pressure until
// the memory reports completion, and locks into a sticky error state.
module mem_access_fsm (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic i_mem_done,
  input  logic i_mem_err,
  output logic o_mem_en,
  output logic o_mem_busy,
  output logic o_err
);
  import wisc_pkg::*;

  mem_state_t r_state;
  mem_state_t w_state_nxt;
  logic       r_mem_en;
  logic       r_err;

  // State register with decoded enable/error flags registered alongside it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_mem_en <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_mem_en <= (w_state_nxt == ST_ACCESS);
      r_err    <= (w_state_nxt == ST_ERR);
    end
  end

  // Next-state logic; a memory error outranks completion, and an unknown
  // encoding is treated as an error so it can never silently resume.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_ACCESS;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (i_mem_err) begin
          w_state_nxt = ST_ERR;
        end else if (i_mem_done) begin
          if (i_start) begin
            w_state_nxt = ST_ACCESS;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_ERR: begin
        w_state_nxt = ST_ERR;
      end
      default: begin
        w_state_nxt = ST_ERR;
      end
    endcase
  end

  // Outputs; busy drops combinationally in the cycle the memory completes.
  always_comb begin
    o_mem_en   = r_mem_en;
    o_err      = r_err;
    o_mem_busy = r_mem_en & ~i_mem_done;
  end

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register of the WISC-SP20 five-stage pipeline. Captures the
// execute stage every cycle it may advance, freezes on stalls, outstanding
// memory accesses, halt or error, and inserts bubbles for flushes (including
// flushes that arrive while the register is frozen).
module ex_mem_reg #(
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [15:0] ex_instr,
  input  logic [15:0] ex_alu_out,
  input  logic [15:0] ex_store_data,
  input  logic [15:0] ex_bj_data,
  input  logic [2:0]  ex_rd,
  input  logic [2:0]  ex_rs,
  input  logic        ex_valid_rd,
  input  logic        ex_reg_write,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic        ex_halt,
  input  logic        stall_in,
  input  logic        flush,
  input  logic        mem_done,
  input  logic [15:0] mem_rdata,
  input  logic        mem_err,
  output logic        m_valid,
  output logic        m_reg_write,
  output logic        m_mem_read,
  output logic        m_mem_write,
  output logic        m_valid_rd,
  output logic        m_halt,
  output logic [15:0] m_instr,
  output logic [15:0] m_alu_out,
  output logic [15:0] m_store_data,
  output logic [15:0] m_bj_data,
  output logic [15:0] m_load_data,
  output logic [2:0]  m_rd,
  output logic [2:0]  m_rs,
  output logic        mem_en,
  output logic        mem_busy,
  output logic        err
);
  import wisc_pkg::*;

  logic        r_valid, r_reg_write, r_mem_read, r_mem_write, r_valid_rd, r_halt;
  logic [15:0] r_instr, r_alu_out, r_store_data, r_bj_data, r_load_data;
  logic [2:0]  r_rd, r_rs;
  logic        r_flush_pend;
  logic        r_halted;

  logic w_mem_en, w_mem_busy, w_err;
  logic w_hold, w_advance, w_bubble, w_capture, w_start_mem;

  assign w_hold      = stall_in | w_mem_busy | r_halted | w_err;
  assign w_advance   = ~w_hold;
  assign w_bubble    = flush | r_flush_pend;
  assign w_capture   = w_advance & ~w_bubble;
  assign w_start_mem = w_capture & is_mem_op(ex_valid, ex_mem_read, ex_mem_write);

  mem_access_fsm u_fsm (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_start_mem),
    .i_mem_done (mem_done),
    .i_mem_err  (mem_err),
    .o_mem_en   (w_mem_en),
    .o_mem_busy (w_mem_busy),
    .o_err      (w_err)
  );

  // Pipeline register bank: capture, bubble, or hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_valid_rd   <= 1'b0;
      r_halt       <= 1'b0;
      r_instr      <= NOP_INSTR;
      r_alu_out    <= 16'h0000;
      r_store_data <= 16'h0000;
      r_bj_data    <= 16'h0000;
      r_rd         <= 3'd0;
      r_rs         <= 3'd0;
    end else if (w_capture) begin
      r_valid      <= ex_valid;
      r_reg_write  <= ex_reg_write & ex_valid;
      r_mem_read   <= ex_mem_read  & ex_valid;
      r_mem_write  <= ex_mem_write & ex_valid;
      r_valid_rd   <= ex_valid_rd  & ex_valid;
      r_halt       <= ex_halt      & ex_valid;
      r_instr      <= ex_instr;
      r_alu_out    <= ex_alu_out;
      r_store_data <= ex_store_data;
      r_bj_data    <= ex_bj_data;
      r_rd         <= ex_rd;
      r_rs         <= ex_rs;
    end else if (w_advance) begin
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_valid_rd   <= 1'b0;
      r_halt       <= 1'b0;
      r_instr      <= NOP_INSTR;
      r_alu_out    <= 16'h0000;
      r_store_data <= 16'h0000;
      r_bj_data    <= 16'h0000;
      r_rd         <= 3'd0;
      r_rs         <= 3'd0;
    end else begin
      r_valid      <= r_valid;
      r_instr      <= r_instr;
    end
  end

  // Remember a flush that arrived while frozen so the next advance is a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_flush_pend <= 1'b0;
    end else if (w_advance) begin
      r_flush_pend <= 1'b0;
    end else if (flush) begin
      r_flush_pend <= 1'b1;
    end else begin
      r_flush_pend <= r_flush_pend;
    end
  end

  // A captured real HALT freezes the register until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_halted <= 1'b0;
    end else if (w_capture & ex_valid & ex_halt) begin
      r_halted <= 1'b1;
    end else begin
      r_halted <= r_halted;
    end
  end

  // Load data is taken from memory on the completing cycle of a read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_load_data <= 16'h0000;
    end else if (w_mem_en & mem_done & r_mem_read) begin
      r_load_data <= mem_rdata;
    end else begin
      r_load_data <= r_load_data;
    end
  end

  assign m_valid      = r_valid;
  assign m_reg_write  = r_reg_write;
  assign m_mem_read   = r_mem_read;
  assign m_mem_write  = r_mem_write;
  assign m_valid_rd   = r_valid_rd;
  assign m_halt       = r_halt;
  assign m_instr      = r_instr;
  assign m_alu_out    = r_alu_out;
  assign m_store_data = r_store_data;
  assign m_bj_data    = r_bj_data;
  assign m_load_data  = r_load_data;
  assign m_rd         = r_rd;
  assign m_rs         = r_rs;
  assign mem_en       = w_mem_en;
  assign mem_busy     = w_mem_busy;
  assign err          = w_err;

endmodule

// File: doc/ex_mem_reg.md
# ex_mem_reg

Pipeline register and data-memory access controller between the execute stage and the memory stage of the WISC-SP20 five-stage pipeline. It captures the execute stage's ALU result, store data and control each cycle. It freezes on pipeline stalls, inserts bubbles on flush, and sequences multi-cycle data-memory accesses. While an access is outstanding it back-pressures upstream stages.

## Interface
Parameters:
- NOP_INSTR, 16'h0800, instruction word presented for bubbles and reset.

Ports:
- clk  in  1  pipeline clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- ex_valid  in  1  execute stage holds a real instruction.
- ex_instr  in  16  instruction word in execute.
- ex_alu_out  in  16  ALU result / memory address.
- ex_store_data  in  16  forwarded Rt value for ST/STU.
- ex_bj_data  in  16  link value for JAL/JALR.
- ex_rd, ex_rs  in  3  destination / base registers.
- ex_valid_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_halt  in  1  control bits.
- stall_in  in  1  hold request from the hazard unit.
- flush  in  1  squash the instruction currently in execute.
- mem_done  in  1  data memory completed the access this cycle.
- mem_rdata  in  16  read data, valid when mem_done.
- mem_err  in  1  data memory error.
- m_valid, m_reg_write, m_mem_read, m_mem_write, m_valid_rd, m_halt  out  1  registered control.
- m_instr, m_alu_out, m_store_data, m_bj_data, m_load_data  out  16  registered data.
- m_rd, m_rs  out  3  registered register ids.
- mem_en  out  1  drive data-memory access (read or write per m_mem_read/m_mem_write).
- mem_busy  out  1  access outstanding; upstream stages must hold.
- err  out  1  sticky memory error.

## Operation
- hold = stall_in | mem_busy | halted | (state==ERR).
- advance = ~hold.
- On advance, with no flush and no flush_pend: capture all ex_* fields. m_valid = ex_valid. Control bits are ANDed with ex_valid.
- On advance with flush or flush_pend, capture a bubble:
  - valid and all control bits 0.
  - m_instr = NOP_INSTR.
  - Data fields 0.
  - flush_pend clears.
- flush asserted while hold: set flush_pend. The next advance captures a bubble, whatever ex_* then holds.
- While hold, all m_* fields retain their values.
- FSM states:
  - IDLE: no access outstanding.
  - ACCESS: data-memory access in progress.
  - ERR: sticky error.
- FSM transitions:
  - IDLE -> ACCESS on an advance capturing a valid memory op.
  - ACCESS: mem_en=1.
  - ACCESS, mem_done=1, with an advance capturing another memory op: stay in ACCESS.
  - ACCESS, mem_done=1, otherwise: go to IDLE.
  - ACCESS, mem_err=1: go to ERR. mem_err has priority over mem_done.
  - ERR: exits only on reset.
- mem_busy = (state==ACCESS) & ~mem_done.
- m_load_data latches mem_rdata when state==ACCESS & mem_done & m_mem_read. It holds otherwise.
- halted is set when a valid halt is captured. It freezes the register until reset.
- err = (state==ERR).

## Timing
- Reset values:
  - All m_* 0, except m_instr = NOP_INSTR.
  - mem_en=0, mem_busy=0, err=0.
  - state=IDLE; flush_pend=0; halted=0.
- Capture latency: one cycle (EX value at edge n appears on m_* after edge n).
- Single-cycle memory (mem_done in the first ACCESS cycle): zero stall cycles. m_load_data is valid the cycle after.
- k-cycle memory: mem_busy high for k-1 cycles. The register advances on the edge ending the mem_done cycle.
- Simultaneous stall_in and mem_done: access completes (FSM leaves ACCESS) but the register does not advance.
- Reset asserted mid-access: immediate return to reset values. Any in-flight access is abandoned.
- Combinational paths:
  - mem_busy depends combinationally on mem_done.
  - No path from ex_* to any output.

## Structure
- The shared package wisc_pkg holds:
  - NOP_INSTR and the opcode constants.
  - The state encoding: IDLE=2'b00, ACCESS=2'b01, ERR=2'b10.
- One sub-module: mem_access_fsm, holding state, mem_en, mem_busy and err. The datapath register bank stays in ex_mem_reg.

## Test plan
- Reset, then one clock: m_instr=16'h0800, m_valid=0, mem_en=0, err=0. Then ADD (ex_alu_out=16'h1234, rd=3) -> next cycle m_alu_out=16'h1234, m_rd=3, m_reg_write=1.
- LD with 3-cycle memory (mem_done in 3rd ACCESS cycle, rdata=16'hBEEF) -> mem_busy high exactly 2 cycles. m_load_data=16'hBEEF afterwards. The following ADD is captured on the completing edge.
- stall_in for 2 cycles with ST in MEM -> m_* unchanged for both cycles. Capture resumes on the third edge.
- flush during stall_in, stall released next cycle -> bubble captured (m_valid=0, m_instr=16'h0800) even though ex_valid=1.
- mem_err during ACCESS -> err=1 from next cycle; the register stays frozen under further stimulus. Reset clears err and state.
- HALT captured -> m_halt=1. The register ignores subsequent ex_* for ≥5 cycles.
